pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 2, cycles one MEM-stage RAM access occupies the shared RAM (legal 1..15).
REQ-002 SHALL have port clk_50MHz  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port id_rs  input  `REG_ADDR_BUS (4)  source register 1 of ID-stage instruction.
REQ-005 SHALL have port id_rt  input  `REG_ADDR_BUS (4)  source register 2 of ID-stage instruction.
REQ-006 SHALL have port id_use_rs / id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-007 SHALL have port ie_mem_read  input  1  EX-stage instruction is a load.
REQ-008 SHALL have port ie_rd  input  `REG_ADDR_BUS  destination register of EX-stage instruction.
REQ-009 SHALL have port ex_branch_taken  input  1  EX stage resolved a taken branch/jump this cycle.
REQ-010 SHALL have port mem_ram_req  input  1  MEM-stage instruction needs the shared RAM.
REQ-011 SHALL have port pc_pause  output  1  IF_ID hold (`PAUSE_ENABLE/`PAUSE_DISABLE).
REQ-012 SHALL have port pc_clear  output  1  IF_ID bubble (`CLEAR_ENABLE/`CLEAR_DISABLE).
REQ-013 SHALL have port pc_hold  output  1  PC register keeps current value.
REQ-014 SHALL have port id_ex_clear  output  1  ID_EX loads a bubble.
REQ-015 SHALL have port stall_all  output  1  freeze ID_EX, EX_MEM, MEM_WB.
REQ-016 SHALL have port ram_owner  output  1  0 = IF fetch owns RAM, 1 = MEM stage owns RAM.
REQ-017 SHALL have port stall_cycles  output  16  saturating count of cycles with pc_hold=1.

Function
REQ-018 SHALL implement FSM states RUN and MEM_WAIT plus a 4-bit wait counter; outputs combinational from state, counter and inputs.
REQ-019 SHALL define load_use = ie_mem_read & ((id_use_rs & id_rs==ie_rd) | (id_use_rt & id_rt==ie_rd)); no register-0 exclusion.
REQ-020 SHALL, in RUN with mem_ram_req=1 and RAM_WAIT>1: enter MEM_WAIT, counter=RAM_WAIT-2; this cycle stall_all=1, pc_pause=ENABLE, pc_hold=1, ram_owner=1, id_ex_clear=0, pc_clear=DISABLE.
REQ-021 SHALL, in MEM_WAIT with counter>0: decrement counter, outputs as REQ-020; branch and load_use ignored.
REQ-022 SHALL treat RUN with mem_ram_req=1 and RAM_WAIT=1, or MEM_WAIT with counter=0, as the final access cycle: ram_owner=1, stall_all=0, pc_hold=1, pc_clear=ENABLE, pc_pause=DISABLE; next state RUN.
REQ-023 SHALL, in the final access cycle, override REQ-022 with branch rules (REQ-024) if ex_branch_taken=1, else with load-use rules (REQ-025) if load_use=1.
REQ-024 SHALL, for ex_branch_taken=1 outside freeze: pc_clear=ENABLE, id_ex_clear=1, pc_pause=DISABLE, pc_hold=0.
REQ-025 SHALL, for load_use=1 without branch, outside freeze: pc_pause=ENABLE, pc_hold=1, id_ex_clear=1, pc_clear=DISABLE.
REQ-026 SHALL, in RUN with no request/hazard: all outputs inactive, ram_owner=0.
REQ-027 SHALL give priority: freeze (REQ-020/021) > branch > load_use > final-access bubble > idle.
REQ-028 SHALL increment stall_cycles every cycle pc_hold=1, saturating at 16'hFFFF.
REQ-029 SHALL never re-enter MEM_WAIT in the same cycle it exits; a request seen in RUN the cycle after exit is a new access.

Reset
REQ-030 SHALL, while rst=0, force state RUN, counter 0, stall_cycles 0, and outputs pc_pause=DISABLE, pc_clear=DISABLE, pc_hold=0, id_ex_clear=0, stall_all=0, ram_owner=0, independent of clock.
REQ-031 SHALL abandon an in-progress MEM_WAIT immediately on reset with no completion cycle.

Structure
REQ-032 SHALL take `PAUSE_*, `CLEAR_*, `REG_ADDR_BUS and state encodings `PIPE_RUN/`PIPE_MEM_WAIT from the shared define.v.
REQ-033 SHALL place the REQ-019 comparator in combinational sub-module load_use_detect.

Verification
REQ-034 SHALL check: ie_mem_read=1, ie_rd=3, id_rs=3, id_use_rs=1 -> one cycle pc_pause=ENABLE, pc_hold=1, id_ex_clear=1.
REQ-035 SHALL check: ex_branch_taken=1 together with load_use -> pc_clear=ENABLE, id_ex_clear=1, pc_pause=DISABLE, pc_hold=0.
REQ-036 SHALL check: RAM_WAIT=3, mem_ram_req held -> 2 cycles stall_all=1, then 1 cycle pc_clear=ENABLE, ram_owner=1, then RUN; stall_cycles +=3.
REQ-037 SHALL check: RAM_WAIT=1, mem_ram_req=1 -> no stall_all, single bubble cycle, state stays RUN.
REQ-038 SHALL check: rst low during MEM_WAIT cycle 1 -> all outputs inactive within same cycle; after release mem_ram_req=0 -> idle.
REQ-039 SHALL check: 65540 cycles of load_use held -> stall_cycles saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared encodings for the pipeline hazard / RAM-arbitration
//               controller: pause/clear polarities, register-address bus,
//               FSM state codes, and a packed bundle of the six control
//               outputs with constructors for each control situation.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define PAUSE_ENABLE   1'b1
`define PAUSE_DISABLE  1'b0
`define CLEAR_ENABLE   1'b1
`define CLEAR_DISABLE  1'b0
`define REG_ADDR_BUS   3:0
`define PIPE_RUN       1'b0
`define PIPE_MEM_WAIT  1'b1
`endif

`default_nettype none

package pipe_ctrl_pkg;

   localparam int WAIT_CNT_W  = 4;
   localparam int STALL_CNT_W = 16;

   // FSM state codes
   localparam logic [0:0] ST_RUN      = `PIPE_RUN;
   localparam logic [0:0] ST_MEM_WAIT = `PIPE_MEM_WAIT;

   // All pipeline control outputs travel together so that each control
   // situation is described in exactly one place.
   typedef struct packed {
      logic pc_pause;
      logic pc_clear;
      logic pc_hold;
      logic id_ex_clear;
      logic stall_all;
      logic ram_owner;
   } ctrl_t;

   // Nothing asserted, fetch owns the RAM.
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c.pc_pause    = `PAUSE_DISABLE;
      c.pc_clear    = `CLEAR_DISABLE;
      c.pc_hold     = 1'b0;
      c.id_ex_clear = 1'b0;
      c.stall_all   = 1'b0;
      c.ram_owner   = 1'b0;
      return c;
   endfunction

   // Whole pipeline frozen while MEM stage occupies the RAM.
   function automatic ctrl_t ctrl_freeze();
      ctrl_t c;
      c             = ctrl_idle();
      c.pc_pause    = `PAUSE_ENABLE;
      c.pc_hold     = 1'b1;
      c.stall_all   = 1'b1;
      c.ram_owner   = 1'b1;
      return c;
   endfunction

   // Taken branch: flush IF_ID and ID_EX, let the PC load the target.
   function automatic ctrl_t ctrl_branch(input logic owner);
      ctrl_t c;
      c             = ctrl_idle();
      c.pc_clear    = `CLEAR_ENABLE;
      c.id_ex_clear = 1'b1;
      c.ram_owner   = owner;
      return c;
   endfunction

   // Load-use: hold PC and IF_ID, insert a bubble into ID_EX.
   function automatic ctrl_t ctrl_load_use(input logic owner);
      ctrl_t c;
      c             = ctrl_idle();
      c.pc_pause    = `PAUSE_ENABLE;
      c.pc_hold     = 1'b1;
      c.id_ex_clear = 1'b1;
      c.ram_owner   = owner;
      return c;
   endfunction

   // Last RAM cycle of a MEM access: fetch lost the RAM, so the IF_ID
   // register receives a bubble while the PC retries the same address.
   function automatic ctrl_t ctrl_final_bubble();
      ctrl_t c;
      c             = ctrl_idle();
      c.pc_clear    = `CLEAR_ENABLE;
      c.pc_hold     = 1'b1;
      c.ram_owner   = 1'b1;
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_load_use_detect.sv
//==============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard comparator. Flags when the EX
//               stage holds a load whose destination matches a source
//               register actually read by the ID-stage instruction.
//               Register 0 is deliberately not excluded.
// Ports       : id_rs, id_rt         - ID-stage source register numbers
//               id_use_rs, id_use_rt - ID instruction reads rs / rt
//               ie_mem_read          - EX-stage instruction is a load
//               ie_rd                - EX-stage destination register
//               load_use             - hazard detected
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_use_detect (
   input  logic                 id_use_rs,
   input  logic                 id_use_rt,
   input  logic [`REG_ADDR_BUS] id_rs,
   input  logic [`REG_ADDR_BUS] id_rt,
   input  logic                 ie_mem_read,
   input  logic [`REG_ADDR_BUS] ie_rd,
   output logic                 load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = id_use_rs && (id_rs == ie_rd);
   assign rt_hit   = id_use_rt && (id_rt == ie_rd);
   assign load_use = ie_mem_read && (rs_hit || rt_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//==============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard and shared-RAM arbitration controller.
//               A MEM-stage RAM access occupies the single-ported RAM for
//               RAM_WAIT cycles: all but the last freeze the pipeline, the
//               last one bubbles IF_ID. Taken branches flush, load-use
//               hazards stall. Also counts cycles with the PC held.
// Ports       : clk_50MHz       - system clock, rising edge
//               rst             - asynchronous reset, active low
//               id_rs/id_rt     - ID-stage source registers
//               id_use_rs/rt    - ID instruction reads rs / rt
//               ie_mem_read     - EX-stage instruction is a load
//               ie_rd           - EX-stage destination register
//               ex_branch_taken - EX resolved a taken branch this cycle
//               mem_ram_req     - MEM-stage instruction needs the RAM
//               pc_pause        - IF_ID hold
//               pc_clear        - IF_ID bubble
//               pc_hold         - PC keeps its value
//               id_ex_clear     - ID_EX loads a bubble
//               stall_all       - freeze ID_EX, EX_MEM, MEM_WB
//               ram_owner       - 0 fetch owns RAM, 1 MEM owns RAM
//               stall_cycles    - saturating count of pc_hold cycles
// Parameters  : RAM_WAIT        - RAM cycles per MEM access, 1..15
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RAM_WAIT = 2
) (
   input  logic                   clk_50MHz,
   input  logic                   rst,
   input  logic [`REG_ADDR_BUS]   id_rs,
   input  logic [`REG_ADDR_BUS]   id_rt,
   input  logic                   id_use_rs,
   input  logic                   id_use_rt,
   input  logic                   ie_mem_read,
   input  logic [`REG_ADDR_BUS]   ie_rd,
   input  logic                   ex_branch_taken,
   input  logic                   mem_ram_req,
   output logic                   pc_pause,
   output logic                   pc_clear,
   output logic                   pc_hold,
   output logic                   id_ex_clear,
   output logic                   stall_all,
   output logic                   ram_owner,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   // A single-cycle access never enters MEM_WAIT; the counter holds the
   // number of freeze cycles still to come after the current one.
   localparam logic                  MULTI_CYCLE = (RAM_WAIT > 1) ? 1'b1 : 1'b0;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD   =
      (RAM_WAIT > 1) ? WAIT_CNT_W'(RAM_WAIT - 2) : '0;

   logic [0:0]            state;
   logic [0:0]            state_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
   logic                  load_use;
   logic                  run_req;
   logic                  freeze;
   logic                  final_access;
   ctrl_t                 ctrl;
   ctrl_t                 ctrl_out;

   load_use_detect u_load_use_detect (
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .ie_mem_read (ie_mem_read),
      .ie_rd       (ie_rd),
      .load_use    (load_use)
   );

   assign run_req      = (state == ST_RUN) && mem_ram_req;
   assign freeze       = (run_req && MULTI_CYCLE)
                      || ((state == ST_MEM_WAIT) && (wait_cnt != '0));
   assign final_access = (run_req && !MULTI_CYCLE)
                      || ((state == ST_MEM_WAIT) && (wait_cnt == '0));

   // Output priority: freeze > branch > load-use > final bubble > idle.
   // During a final access cycle the RAM still belongs to MEM.
   always_comb begin
      ctrl = ctrl_idle();
      if (freeze) begin
         ctrl = ctrl_freeze();
      end else if (ex_branch_taken) begin
         ctrl = ctrl_branch(final_access);
      end else if (load_use) begin
         ctrl = ctrl_load_use(final_access);
      end else if (final_access) begin
         ctrl = ctrl_final_bubble();
      end
   end

   // Outputs drop to inactive as soon as reset asserts, without waiting
   // for the state registers to be observed through a clock edge.
   assign ctrl_out    = rst ? ctrl : ctrl_idle();
   assign pc_pause    = ctrl_out.pc_pause;
   assign pc_clear    = ctrl_out.pc_clear;
   assign pc_hold     = ctrl_out.pc_hold;
   assign id_ex_clear = ctrl_out.id_ex_clear;
   assign stall_all   = ctrl_out.stall_all;
   assign ram_owner   = ctrl_out.ram_owner;

   // Exit from MEM_WAIT always lands in RUN, so a request present on the
   // following cycle starts a fresh access.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         ST_RUN: begin
            if (run_req && MULTI_CYCLE) begin
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = WAIT_LOAD;
            end
         end
         default: begin
            if (wait_cnt != '0) begin
               wait_cnt_nxt = wait_cnt - 1'b1;
            end else begin
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge rst) begin
      if (!rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_ff @(posedge clk_50MHz or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (ctrl.pc_hold && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none

module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  id_rs, id_rt, ie_rd;
   logic        id_use_rs, id_use_rt, ie_mem_read, ex_branch_taken, mem_ram_req;

   logic        pp3, pcl3, ph3, iec3, sa3, ro3;
   logic        pp1, pcl1, ph1, iec1, sa1, ro1;
   logic [15:0] sc_dut3, sc_dut1;
   logic [5:0]  obs3, obs1;
   logic [5:0]  exp3, exp1;

   int rem3, rem1;      // remaining RAM cycles of the access in progress
   int sc3, sc1;        // expected stall_cycles
   int checks, passed;

   // Output vector order: {pc_pause, pc_clear, pc_hold, id_ex_clear, stall_all, ram_owner}
   assign obs3 = {pp3, pcl3, ph3, iec3, sa3, ro3};
   assign obs1 = {pp1, pcl1, ph1, iec1, sa1, ro1};

   pipe_ctrl #(.RAM_WAIT(3)) dut3 (
      .clk_50MHz(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ie_mem_read(ie_mem_read),
      .ie_rd(ie_rd), .ex_branch_taken(ex_branch_taken), .mem_ram_req(mem_ram_req),
      .pc_pause(pp3), .pc_clear(pcl3), .pc_hold(ph3), .id_ex_clear(iec3),
      .stall_all(sa3), .ram_owner(ro3), .stall_cycles(sc_dut3));

   pipe_ctrl #(.RAM_WAIT(1)) dut1 (
      .clk_50MHz(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ie_mem_read(ie_mem_read),
      .ie_rd(ie_rd), .ex_branch_taken(ex_branch_taken), .mem_ram_req(mem_ram_req),
      .pc_pause(pp1), .pc_clear(pcl1), .pc_hold(ph1), .id_ex_clear(iec1),
      .stall_all(sa1), .ram_owner(ro1), .stall_cycles(sc_dut1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int cycles_now(input int rw, input int rem);
      if (rem > 0) return rem;
      if (mem_ram_req) return rw;
      return 0;
   endfunction

   function automatic logic [5:0] model_out(input int rw, input int rem);
      int   now;
      logic lu;
      logic owner;
      if (!rst) return 6'b000000;
      now   = cycles_now(rw, rem);
      lu    = ie_mem_read && ((id_use_rs && id_rs == ie_rd) || (id_use_rt && id_rt == ie_rd));
      owner = (now == 1);
      if (now > 1)         return 6'b101011;
      if (ex_branch_taken) return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, owner};
      if (lu)              return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, owner};
      if (now == 1)        return 6'b011001;
      return 6'b000000;
   endfunction

   function automatic int model_next(input int rw, input int rem);
      int now;
      now = cycles_now(rw, rem);
      return (now > 0) ? now - 1 : 0;
   endfunction

   task automatic predict();
      exp3 = model_out(3, rem3);
      exp1 = model_out(1, rem1);
   endtask

   task automatic advance();
      logic [5:0] e3, e1;
      @(posedge clk);
      if (!rst) begin
         rem3 = 0; rem1 = 0; sc3 = 0; sc1 = 0;
      end else begin
         e3 = model_out(3, rem3);
         e1 = model_out(1, rem1);
         if (e3[3] && sc3 < 65535) sc3++;
         if (e1[3] && sc1 < 65535) sc1++;
         rem3 = model_next(3, rem3);
         rem1 = model_next(1, rem1);
      end
      @(negedge clk);
   endtask

   task automatic set_in(input logic [3:0] rs, input logic [3:0] rt, input logic urs,
                         input logic urt, input logic mr, input logic [3:0] rd,
                         input logic br, input logic req);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      ie_mem_read = mr; ie_rd = rd; ex_branch_taken = br; mem_ram_req = req;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      advance();
      advance();
      #1;
      checks++;
      if (obs3 !== 6'b000000) $display("FAIL reset_out3 got=%b want=%b", obs3, 6'b000000);
      else passed++;
      checks++;
      if (obs1 !== 6'b000000) $display("FAIL reset_out1 got=%b want=%b", obs1, 6'b000000);
      else passed++;
      checks++;
      if (sc_dut3 !== 16'd0) $display("FAIL reset_cnt3 got=%0d want=0", sc_dut3);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (obs3 !== 6'b000000) $display("FAIL idle_after_reset got=%b want=%b", obs3, 6'b000000);
      else passed++;
      advance();
   endtask

   task automatic test_load_use();
      set_in(4'd3, 4'd9, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
      #1;
      predict();
      checks++;
      if (obs3 !== 6'b101100) $display("FAIL load_use3 got=%b want=%b", obs3, 6'b101100);
      else passed++;
      checks++;
      if (obs1 !== exp1) $display("FAIL load_use1 got=%b want=%b", obs1, exp1);
      else passed++;
      advance();
      // same rt match but rt not used: no hazard
      set_in(4'd1, 4'd3, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs3 !== 6'b000000) $display("FAIL load_use_rt_unused got=%b want=%b", obs3, 6'b000000);
      else passed++;
      advance();
   endtask

   task automatic test_branch();
      set_in(4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
      #1;
      checks++;
      if (obs3 !== 6'b010100) $display("FAIL branch_over_lu got=%b want=%b", obs3, 6'b010100);
      else passed++;
      checks++;
      if (obs1 !== 6'b010100) $display("FAIL branch_over_lu1 got=%b want=%b", obs1, 6'b010100);
      else passed++;
      advance();
      set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      advance();
   endtask

   task automatic test_mem_wait();
      int base3, base1;
      base3 = sc3;
      base1 = sc1;
      for (int i = 0; i < 3; i++) begin
         set_in(4'd2, 4'd2, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b1);
         #1;
         checks++;
         if (obs3 !== ((i < 2) ? 6'b101011 : 6'b011001))
            $display("FAIL mem_wait3 cyc=%0d got=%b want=%b", i, obs3, (i < 2) ? 6'b101011 : 6'b011001);
         else passed++;
         checks++;
         if (obs1 !== 6'b011001) $display("FAIL mem_wait1 cyc=%0d got=%b want=%b", i, obs1, 6'b011001);
         else passed++;
         advance();
      end
      set_in(4'd2, 4'd2, 1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs3 !== 6'b000000) $display("FAIL mem_wait_back_to_run got=%b want=%b", obs3, 6'b000000);
      else passed++;
      checks++;
      if (sc_dut3 !== 16'(base3 + 3)) $display("FAIL mem_wait_cnt3 got=%0d want=%0d", sc_dut3, base3 + 3);
      else passed++;
      checks++;
      if (sc_dut1 !== 16'(base1 + 3)) $display("FAIL mem_wait_cnt1 got=%0d want=%0d", sc_dut1, base1 + 3);
      else passed++;
      advance();
   endtask

   task automatic test_reset_mid_wait();
      set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      advance();
      set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if (obs3 !== 6'b101011) $display("FAIL mid_wait_freeze got=%b want=%b", obs3, 6'b101011);
      else passed++;
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (obs3 !== 6'b000000) $display("FAIL mid_wait_reset_out got=%b want=%b", obs3, 6'b000000);
      else passed++;
      checks++;
      if (sc_dut3 !== 16'd0) $display("FAIL mid_wait_reset_cnt got=%0d want=0", sc_dut3);
      else passed++;
      rem3 = 0; rem1 = 0; sc3 = 0; sc1 = 0;
      advance();
      rst = 1'b1;
      #1;
      checks++;
      if (obs3 !== 6'b000000) $display("FAIL mid_wait_after_release got=%b want=%b", obs3, 6'b000000);
      else passed++;
      advance();
      #1;
      checks++;
      if (obs3 !== 6'b000000) $display("FAIL mid_wait_no_completion got=%b want=%b", obs3, 6'b000000);
      else passed++;
      advance();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
         #1;
         predict();
         checks++;
         if (obs3 !== exp3) $display("FAIL rand_out3 cyc=%0d got=%b want=%b", i, obs3, exp3);
         else passed++;
         checks++;
         if (obs1 !== exp1) $display("FAIL rand_out1 cyc=%0d got=%b want=%b", i, obs1, exp1);
         else passed++;
         checks++;
         if (sc_dut3 !== 16'(sc3) || sc_dut1 !== 16'(sc1))
            $display("FAIL rand_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, sc_dut3, sc_dut1, sc3, sc1);
         else passed++;
         advance();
      end
   endtask

   task automatic test_saturation();
      set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
      for (int i = 0; i < 65540; i++) advance();
      #1;
      checks++;
      if (sc_dut3 !== 16'hFFFF) $display("FAIL sat_cnt3 got=%h want=ffff", sc_dut3);
      else passed++;
      checks++;
      if (sc_dut1 !== 16'hFFFF) $display("FAIL sat_cnt1 got=%h want=ffff", sc_dut1);
      else passed++;
      checks++;
      if (sc3 != 65535) $display("FAIL sat_model got=%0d want=65535", sc3);
      else passed++;
      advance();
      #1;
      checks++;
      if (sc_dut3 !== 16'hFFFF) $display("FAIL sat_hold got=%h want=ffff", sc_dut3);
      else passed++;
   endtask

   initial begin
      checks = 0; passed = 0;
      rem3 = 0; rem1 = 0; sc3 = 0; sc1 = 0;
      rst = 1'b0;
      set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_reset_mid_wait();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
